// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: register-number width, operand-forwarding select codes,
// the architectural zero register and the per-stage destination/control entry.
// No logic; imported by the destination tracker and its forwarding comparators.
package mips_pipe_pkg;

   localparam int REG_ADDR_W = 5;

   // EX operand mux selects (2'b11 is never produced)
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Destination and control bits that travel alongside an instruction
   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic                  regwrite;
      logic                  memread;
   } stage_t;

endpackage

// File: rtl/dest_reg_track_unit_fwd_select.sv
// Purpose: priority compare of one EX source register against the MEM and WB producers.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select is valid whenever its inputs are.
module fwd_select
   import mips_pipe_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_regwrite,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic                  wb_regwrite,
   output logic [1:0]            sel
);

   // MEM is checked first so the youngest producer wins; $0 is never forwarded
   always_comb begin
      sel = FWD_RF;
      if (mem_regwrite && (mem_dest != REG_ZERO) && (mem_dest == src)) begin
         sel = FWD_MEM;
      end else if (wb_regwrite && (wb_dest != REG_ZERO) && (wb_dest == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/dest_reg_track_unit.sv
// Purpose: shadow pipeline of destinations/controls (EX/MEM/WB), forwarding selects, load-use stall.
// Latency: forwarding and Stall are combinational; WB destination appears 3 edges after ID.
// Backpressure: Stall holds PC/IF-ID upstream and bubbles EX; EX/MEM/WB always advance.
module dest_reg_track_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [REG_ADDR_W-1:0]  WriteReg_ID,
   input  logic                   RegWrite_ID,
   input  logic                   MemRead_ID,
   input  logic [REG_ADDR_W-1:0]  Rs_ID,
   input  logic [REG_ADDR_W-1:0]  Rt_ID,
   input  logic                   UsesRt_ID,
   input  logic                   Flush,
   output logic [1:0]             ForwardA,
   output logic [1:0]             ForwardB,
   output logic                   Stall,
   output logic [REG_ADDR_W-1:0]  WriteReg_WB,
   output logic                   RegWrite_WB,
   output logic [STALL_CNT_W-1:0] StallCount
);
   import mips_pipe_pkg::stage_t;
   import mips_pipe_pkg::REG_ZERO;

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   stage_t                   ex_q;
   stage_t                   mem_q;
   logic [REG_ADDR_W-1:0]    rs_ex;
   logic [REG_ADDR_W-1:0]    rt_ex;
   logic [REG_ADDR_W-1:0]    dest_wb;
   logic                     regwrite_wb;
   logic [STALL_CNT_W-1:0]   stall_cnt;
   logic                     stall;

   // The MEM load flag is only of interest to observers checking the load-use
   // guarantee; no output depends on it.
   logic unused_memread_mem;
   assign unused_memread_mem = mem_q.memread;

   // Load in EX whose nonzero destination is read by the ID instruction
   always_comb begin
      stall = ex_q.memread && (ex_q.dest != REG_ZERO) &&
              ((ex_q.dest == Rs_ID) || (UsesRt_ID && (ex_q.dest == Rt_ID)));
   end

   // EX entry: bubble on stall or flush; rt only tracked when actually read
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ex_q  <= '0;
         rs_ex <= '0;
         rt_ex <= '0;
      end else if (stall || Flush) begin
         ex_q  <= '0;
         rs_ex <= '0;
         rt_ex <= '0;
      end else begin
         ex_q  <= '{dest: WriteReg_ID, regwrite: RegWrite_ID, memread: MemRead_ID};
         rs_ex <= Rs_ID;
         rt_ex <= UsesRt_ID ? Rt_ID : REG_ZERO;
      end
   end

   // MEM and WB advance every edge; a stall never freezes them
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mem_q       <= '0;
         dest_wb     <= '0;
         regwrite_wb <= 1'b0;
      end else begin
         mem_q       <= ex_q;
         dest_wb     <= mem_q.dest;
         regwrite_wb <= mem_q.regwrite;
      end
   end

   // Saturating count of stall cycles
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   fwd_select u_fwd_rs (
      .src          (rs_ex),
      .mem_dest     (mem_q.dest),
      .mem_regwrite (mem_q.regwrite),
      .wb_dest      (dest_wb),
      .wb_regwrite  (regwrite_wb),
      .sel          (ForwardA)
   );

   fwd_select u_fwd_rt (
      .src          (rt_ex),
      .mem_dest     (mem_q.dest),
      .mem_regwrite (mem_q.regwrite),
      .wb_dest      (dest_wb),
      .wb_regwrite  (regwrite_wb),
      .sel          (ForwardB)
   );

   assign Stall       = stall;
   assign WriteReg_WB = dest_wb;
   assign RegWrite_WB = regwrite_wb;
   assign StallCount  = stall_cnt;

endmodule

// File: tb/tb_dest_reg_track_unit.sv
// Purpose: self-checking bench for dest_reg_track_unit (table vectors + scoreboard queue).
// Latency: each vector is driven 1ns after a rising edge and checked on the falling edge.
// Backpressure: the bench models the stall by re-presenting the held ID instruction.
module tb_dest_reg_track_unit;

   localparam int AW    = 5;
   localparam int CW    = 10;
   localparam int CMAX  = (1 << CW) - 1;
   localparam int NPAIR = CMAX + 7;
   localparam int NVEC  = 44;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [AW-1:0] WriteReg_ID;
   logic          RegWrite_ID;
   logic          MemRead_ID;
   logic [AW-1:0] Rs_ID;
   logic [AW-1:0] Rt_ID;
   logic          UsesRt_ID;
   logic          Flush;
   logic [1:0]    ForwardA;
   logic [1:0]    ForwardB;
   logic          Stall;
   logic [AW-1:0] WriteReg_WB;
   logic          RegWrite_WB;
   logic [CW-1:0] StallCount;

   dest_reg_track_unit #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .WriteReg_ID (WriteReg_ID),
      .RegWrite_ID (RegWrite_ID),
      .MemRead_ID  (MemRead_ID),
      .Rs_ID       (Rs_ID),
      .Rt_ID       (Rt_ID),
      .UsesRt_ID   (UsesRt_ID),
      .Flush       (Flush),
      .ForwardA    (ForwardA),
      .ForwardB    (ForwardB),
      .Stall       (Stall),
      .WriteReg_WB (WriteReg_WB),
      .RegWrite_WB (RegWrite_WB),
      .StallCount  (StallCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [AW-1:0] wr;
      logic          rw;
      logic          mr;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          ut;
      logic          fl;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic          st;
      logic [AW-1:0] wwb;
      logic          rwwb;
      int            sc;
   } vec_t;

   vec_t tbl [NVEC];
   vec_t exp_q [$];

   int tests     = 0;
   int fails     = 0;
   int inv_viol  = 0;

   function automatic vec_t mk(input int wr, input int rw, input int mr, input int rs,
                               input int rt, input int ut, input int fl,
                               input int fa, input int fb, input int st,
                               input int wwb, input int rwwb, input int sc);
      vec_t v;
      v.wr   = AW'(wr);
      v.rw   = 1'(rw);
      v.mr   = 1'(mr);
      v.rs   = AW'(rs);
      v.rt   = AW'(rt);
      v.ut   = 1'(ut);
      v.fl   = 1'(fl);
      v.fa   = 2'(fa);
      v.fb   = 2'(fb);
      v.st   = 1'(st);
      v.wwb  = AW'(wwb);
      v.rwwb = 1'(rwwb);
      v.sc   = sc;
      return v;
   endfunction

   function automatic vec_t nop(input int fa, input int fb, input int st,
                                input int wwb, input int rwwb, input int sc);
      return mk(0, 0, 0, 0, 0, 0, 0, fa, fb, st, wwb, rwwb, sc);
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic set_id(input vec_t v);
      WriteReg_ID = v.wr;
      RegWrite_ID = v.rw;
      MemRead_ID  = v.mr;
      Rs_ID       = v.rs;
      Rt_ID       = v.rt;
      UsesRt_ID   = v.ut;
      Flush       = v.fl;
   endtask

   // Drive one ID instruction, queue its expected outputs, compare on the falling edge
   task automatic drive(input int idx, input vec_t v);
      vec_t e;
      @(posedge Clk);
      #1;
      set_id(v);
      exp_q.push_back(v);
      @(negedge Clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d ForwardA", idx), int'(ForwardA), int'(e.fa));
      chk($sformatf("v%0d ForwardB", idx), int'(ForwardB), int'(e.fb));
      chk($sformatf("v%0d Stall", idx), int'(Stall), int'(e.st));
      chk($sformatf("v%0d WriteReg_WB", idx), int'(WriteReg_WB), int'(e.wwb));
      chk($sformatf("v%0d RegWrite_WB", idx), int'(RegWrite_WB), int'(e.rwwb));
      chk($sformatf("v%0d StallCount", idx), int'(StallCount), e.sc);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ForwardA"}, int'(ForwardA), 0);
      chk({tag, " ForwardB"}, int'(ForwardB), 0);
      chk({tag, " Stall"}, int'(Stall), 0);
      chk({tag, " WriteReg_WB"}, int'(WriteReg_WB), 0);
      chk({tag, " RegWrite_WB"}, int'(RegWrite_WB), 0);
      chk({tag, " StallCount"}, int'(StallCount), 0);
   endtask

   // A load in MEM must never be the producer of an operand currently in EX
   always @(negedge Clk) begin
      if (!Rst && dut.mem_q.memread && dut.mem_q.regwrite && (dut.mem_q.dest != 0) &&
          ((dut.mem_q.dest == dut.rs_ex) || (dut.mem_q.dest == dut.rt_ex))) begin
         inv_viol++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va;
      vec_t vb;

      //            wr rw mr rs rt ut fl   fa fb st wwb rwwb sc
      // EX-EX forward of $3
      tbl[0]  = mk( 3, 1, 0, 1, 2, 1, 0,   0, 0, 0,  0, 0, 0);
      tbl[1]  = mk(10, 1, 0, 3, 4, 1, 0,   0, 0, 0,  0, 0, 0);
      tbl[2]  = nop(                        1, 0, 0,  0, 0, 0);
      tbl[3]  = nop(                        0, 0, 0,  3, 1, 0);
      tbl[4]  = nop(                        0, 0, 0, 10, 1, 0);
      tbl[5]  = nop(                        0, 0, 0,  0, 0, 0);
      // $5 produced at distance 1 and 2: MEM wins
      tbl[6]  = mk( 5, 1, 0, 1, 0, 0, 0,   0, 0, 0,  0, 0, 0);
      tbl[7]  = mk( 5, 1, 0, 1, 2, 1, 0,   0, 0, 0,  0, 0, 0);
      tbl[8]  = mk(11, 1, 0, 5, 5, 1, 0,   0, 0, 0,  0, 0, 0);
      tbl[9]  = nop(                        1, 1, 0,  5, 1, 0);
      tbl[10] = nop(                        0, 0, 0,  5, 1, 0);
      // $5 produced at distance 2 only: WB forward
      tbl[11] = mk( 5, 1, 0, 1, 2, 1, 0,   0, 0, 0, 11, 1, 0);
      tbl[12] = nop(                        0, 0, 0,  0, 0, 0);
      tbl[13] = mk(12, 1, 0, 5, 5, 1, 0,   0, 0, 0,  0, 0, 0);
      tbl[14] = nop(                        2, 2, 0,  5, 1, 0);
      tbl[15] = nop(                        0, 0, 0,  0, 0, 0);
      tbl[16] = nop(                        0, 0, 0, 12, 1, 0);
      tbl[17] = nop(                        0, 0, 0,  0, 0, 0);
      // lw $4 then add $6,$4,$7: one stall, add re-presented, then WB forward
      tbl[18] = mk( 4, 1, 1, 1, 4, 0, 0,   0, 0, 0,  0, 0, 0);
      tbl[19] = mk( 6, 1, 0, 4, 7, 1, 0,   0, 0, 1,  0, 0, 0);
      tbl[20] = mk( 6, 1, 0, 4, 7, 1, 0,   0, 0, 0,  0, 0, 1);
      tbl[21] = nop(                        2, 0, 0,  4, 1, 1);
      tbl[22] = nop(                        0, 0, 0,  0, 0, 1);
      // lw $0 then reader of $0; lw $8 then addi with unused rt=8
      tbl[23] = mk( 0, 1, 1, 1, 0, 0, 0,   0, 0, 0,  6, 1, 1);
      tbl[24] = mk(13, 1, 0, 0, 0, 1, 0,   0, 0, 0,  0, 0, 1);
      tbl[25] = mk( 8, 1, 1, 2, 8, 0, 0,   0, 0, 0,  0, 0, 1);
      tbl[26] = mk( 9, 1, 0, 2, 8, 0, 0,   0, 0, 0,  0, 1, 1);
      tbl[27] = nop(                        0, 0, 0, 13, 1, 1);
      tbl[28] = nop(                        0, 0, 0,  8, 1, 1);
      tbl[29] = nop(                        0, 0, 0,  9, 1, 1);
      // producer of $2 flushed: no forwarding of $2, WB slot empty
      tbl[30] = mk( 2, 1, 0, 1, 1, 1, 1,   0, 0, 0,  0, 0, 1);
      tbl[31] = mk(14, 1, 0, 2, 2, 1, 0,   0, 0, 0,  0, 0, 1);
      tbl[32] = mk(15, 1, 0, 2, 2, 1, 0,   0, 0, 0,  0, 0, 1);
      tbl[33] = mk(16, 1, 0, 2, 2, 1, 0,   0, 0, 0,  0, 0, 1);
      tbl[34] = nop(                        0, 0, 0, 14, 1, 1);
      // flush and stall together: bubble, count still increments
      tbl[35] = mk( 3, 1, 1, 1, 0, 0, 0,   0, 0, 0, 15, 1, 1);
      tbl[36] = mk(17, 1, 0, 3, 0, 1, 1,   0, 0, 1, 16, 1, 1);
      tbl[37] = nop(                        0, 0, 0,  0, 0, 2);
      tbl[38] = nop(                        0, 0, 0,  3, 1, 2);
      tbl[39] = nop(                        0, 0, 0,  0, 0, 2);
      // fill the pipeline ahead of a mid-stream reset
      tbl[40] = mk( 9, 1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 2);
      tbl[41] = mk( 5, 1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 2);
      tbl[42] = mk( 6, 1, 1, 5, 0, 0, 0,   0, 0, 0,  0, 0, 2);
      tbl[43] = mk( 7, 1, 0, 6, 0, 1, 0,   1, 0, 1,  9, 1, 2);

      Rst = 1'b1;
      set_id(nop(0, 0, 0, 0, 0, 0));
      #3;
      chk_all_zero("reset");
      @(negedge Clk);
      Rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         drive(i, tbl[i]);
      end

      // Reset with the pipeline full: outputs clear before any clock edge
      #2;
      Rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(negedge Clk);
      Rst = 1'b0;

      // Alternate load / dependent consumer until the counter saturates
      va = mk( 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vb = mk(10, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NPAIR; i++) begin
         @(posedge Clk);
         #1;
         set_id(va);
         @(negedge Clk);
         chk($sformatf("sat%0d count", i), int'(StallCount), (i < CMAX) ? i : CMAX);
         chk($sformatf("sat%0d load stall", i), int'(Stall), 0);
         @(posedge Clk);
         #1;
         set_id(vb);
         @(negedge Clk);
         chk($sformatf("sat%0d use stall", i), int'(Stall), 1);
      end
      @(posedge Clk);
      #1;
      set_id(nop(0, 0, 0, 0, 0, 0));
      @(negedge Clk);
      chk("sat final count", int'(StallCount), CMAX);
      chk("sat final stall", int'(Stall), 0);

      chk("load-use invariant violations", inv_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
